// File: rtl/rs_enc_pkg.sv
// Shared types, FSM encodings and elaboration-time Galois-field helpers for the RS encoder.
package rs_enc_pkg;

    localparam int unsigned SYM_BW_BW = 12;  // widest supported symbol
    localparam int unsigned R_BW      = 8;   // parity count must stay below 2^R_BW
    localparam int unsigned R_CAP     = 1 << R_BW;
    localparam int unsigned BIT_IW    = $clog2(SYM_BW_BW + 1);
    localparam int unsigned VEC_IW    = $clog2(R_CAP * SYM_BW_BW);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    // Coefficient j of the generator lives at [j*SYM_BW_BW +: SYM_BW_BW].
    typedef logic [R_CAP*SYM_BW_BW-1:0] coef_vec_t;

    function automatic logic [SYM_BW_BW-1:0] gf_mul(
        input logic [SYM_BW_BW-1:0] a,
        input logic [SYM_BW_BW-1:0] b,
        input logic [SYM_BW_BW:0]   poly,
        input int unsigned          m
    );
        logic [SYM_BW_BW:0] p;
        p = '0;
        for (int i = int'(SYM_BW_BW) - 1; i >= 0; i--) begin
            if (i < int'(m)) begin
                p = p << 1;
                if (p[BIT_IW'(m)]) p = p ^ poly;
                if (b[BIT_IW'(i)]) p = p ^ {1'b0, a};
            end
        end
        return p[SYM_BW_BW-1:0];
    endfunction

    // Monic g(x) = prod (x - a^(fcr+i)); only g[0..r-1] are needed by the LFSR.
    function automatic coef_vec_t gen_poly(
        input int unsigned          r,
        input int unsigned          fcr,
        input logic [SYM_BW_BW:0]   poly,
        input int unsigned          m
    );
        coef_vec_t            g;
        logic [SYM_BW_BW-1:0] root, gj, gprev;
        g    = '0;
        g[SYM_BW_BW-1:0] = SYM_BW_BW'(1);
        root = SYM_BW_BW'(1);
        for (int unsigned e = 0; e < fcr; e++) root = gf_mul(root, SYM_BW_BW'(2), poly, m);
        for (int i = 0; i < int'(r); i++) begin
            for (int j = i + 1; j >= 0; j--) begin
                gj    = '0;
                gprev = '0;
                if (j <= i) gj = g[VEC_IW'(j * int'(SYM_BW_BW)) +: SYM_BW_BW];
                if (j > 0)  gprev = g[VEC_IW'((j - 1) * int'(SYM_BW_BW)) +: SYM_BW_BW];
                g[VEC_IW'(j * int'(SYM_BW_BW)) +: SYM_BW_BW] = gprev ^ gf_mul(gj, root, poly, m);
            end
            root = gf_mul(root, SYM_BW_BW'(2), poly, m);
        end
        return g;
    endfunction

endpackage

// File: rtl/rs_enc_lfsr_core.sv
// R_NUM-stage RS division register with constant generator multipliers.
module rs_enc_lfsr_core
    import rs_enc_pkg::*;
#(
    parameter int unsigned SYM_BW    = 8,
    parameter int unsigned R_NUM     = 16,
    parameter int unsigned PRIM_POLY = 'h11D,
    parameter int unsigned FCR       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fb_sel,
    input  logic              clr,
    input  logic [SYM_BW-1:0] din,
    output logic [SYM_BW-1:0] par_out
);

    localparam logic [SYM_BW_BW:0] POLY = (SYM_BW_BW + 1)'(PRIM_POLY);
    localparam coef_vec_t          GEN  = gen_poly(R_NUM, FCR, POLY, SYM_BW);

    logic [SYM_BW-1:0] r    [R_NUM];
    logic [SYM_BW-1:0] base [R_NUM];
    logic [SYM_BW-1:0] nxt  [R_NUM];
    logic [SYM_BW-1:0] prod [R_NUM];
    logic [SYM_BW-1:0] fb;

    // A clear in the same cycle as a shift makes the shift start from an empty register.
    always_comb begin
        for (int i = 0; i < int'(R_NUM); i++) base[i] = clr ? '0 : r[i];
    end

    assign fb = fb_sel ? (din ^ base[R_NUM-1]) : '0;

    for (genvar i = 0; i < int'(R_NUM); i++) begin : g_stage
        localparam logic [SYM_BW_BW-1:0] C = GEN[i*SYM_BW_BW +: SYM_BW_BW];
        assign prod[i] = SYM_BW'(gf_mul(SYM_BW_BW'(fb), C, POLY, SYM_BW));
    end

    always_comb begin
        nxt[0] = prod[0];
        for (int i = 1; i < int'(R_NUM); i++) nxt[i] = base[i-1] ^ prod[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(R_NUM); i++) r[i] <= '0;
        end else if (en || clr) begin
            for (int i = 0; i < int'(R_NUM); i++) r[i] <= en ? nxt[i] : base[i];
        end
    end

    assign par_out = r[R_NUM-1];

endmodule

// File: rtl/rs_enc_stream.sv
// Streaming systematic RS encoder with per-frame shortened length and two-sided backpressure.
module rs_enc_stream
    import rs_enc_pkg::*;
#(
    parameter int unsigned SYM_BW    = 8,
    parameter int unsigned N_MAX     = 255,
    parameter int unsigned R_NUM     = 16,
    parameter int unsigned PRIM_POLY = 'h11D,
    parameter int unsigned FCR       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_val,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [SYM_BW-1:0] din,
    output logic              din_rdy,
    output logic              dout_val,
    input  logic              dout_rdy,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [SYM_BW-1:0] dout,
    output logic              frm_err
);

    localparam int unsigned      CNT_W  = $clog2(N_MAX + 1);
    localparam logic [CNT_W-1:0] K_MAX  = CNT_W'(N_MAX - R_NUM);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(R_NUM - 1);

    logic [1:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [SYM_BW-1:0] dout_n, par_out;
    logic              val_n, sop_n, eop_n, err_n, live;
    logic              ld, xfer, en, fb_sel, clr;

    assign ld      = !dout_val || dout_rdy;
    assign din_rdy = live && ld && (state != PARITY);
    assign xfer    = din_val && din_rdy;

    rs_enc_lfsr_core #(
        .SYM_BW    (SYM_BW),
        .R_NUM     (R_NUM),
        .PRIM_POLY (PRIM_POLY),
        .FCR       (FCR)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .fb_sel  (fb_sel),
        .clr     (clr),
        .din     (din),
        .par_out (par_out)
    );

    // Next state, counter and output-register load.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dout_n  = dout;
        val_n   = dout_val;
        sop_n   = dout_sop;
        eop_n   = dout_eop;
        err_n   = 1'b0;
        en      = 1'b0;
        fb_sel  = 1'b0;
        clr     = 1'b0;
        if (ld) begin
            val_n = 1'b0;
            sop_n = 1'b0;
            eop_n = 1'b0;
        end
        case (state)
            IDLE, DATA: begin
                if (xfer) begin
                    if (!din_sop && state == IDLE) begin
                        err_n = 1'b1;
                    end else begin
                        en     = 1'b1;
                        fb_sel = 1'b1;
                        dout_n = din;
                        val_n  = 1'b1;
                        sop_n  = din_sop;
                        state_n = DATA;
                        if (din_sop) begin
                            // sop inside a frame abandons the old parity and restarts.
                            clr   = (state == DATA);
                            err_n = (state == DATA);
                            cnt_n = CNT_W'(1);
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                        if (din_eop || cnt_n == K_MAX) begin
                            state_n = PARITY;
                            err_n   = err_n || !din_eop;
                            cnt_n   = '0;
                        end
                    end
                end
            end
            PARITY: begin
                if (ld) begin
                    en     = 1'b1;
                    dout_n = par_out;
                    val_n  = 1'b1;
                    cnt_n  = cnt + CNT_W'(1);
                    if (cnt == P_LAST) begin
                        eop_n   = 1'b1;
                        clr     = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dout     <= '0;
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            frm_err  <= 1'b0;
            live     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dout     <= dout_n;
            dout_val <= val_n;
            dout_sop <= sop_n;
            dout_eop <= eop_n;
            frm_err  <= err_n;
            live     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rs_enc_stream.sv
// Scoreboard bench for rs_enc_stream at default parameters (GF(256), 0x11D, R=16, FCR=0).
module tb_rs_enc_stream;

    localparam int R    = 16;
    localparam int KMAX = 239;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       din_val = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [7:0] din = '0;
    logic       din_rdy, dout_val, dout_sop, dout_eop, frm_err;
    logic       dout_rdy = 1'b1;
    logic [7:0] dout;

    rs_enc_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_val  (din_val),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .din      (din),
        .din_rdy  (din_rdy),
        .dout_val (dout_val),
        .dout_rdy (dout_rdy),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout     (dout),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sym;
        logic       sop;
        logic       eop;
        logic       par;
    } item_t;

    item_t exp_q[$];
    item_t it;
    int    n_cmp = 0, n_err = 0;
    int    err_cnt = 0, out_cnt = 0, par_seen = 0;
    int    cyc = 0, sop_cyc = 0, eop_cyc = 0;
    bit    bp_en = 1'b0;
    int    gexp [0:511];
    int    glog [0:255];
    logic [7:0] gen [0:R];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        dout_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (frm_err) err_cnt++;
        if (rst_n && dout_val && exp_q.size() > 0 && exp_q[0].par && !exp_q[0].eop) begin
            n_cmp++;
            if (din_rdy !== 1'b0) begin
                n_err++;
                $display("FAIL din_rdy_in_parity: got %b, required 0 (cycle %0d)", din_rdy, cyc);
            end
        end
        if (rst_n && dout_val && dout_rdy) begin
            n_cmp++;
            out_cnt++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got sym=%02h sop=%b eop=%b, required no output", dout, dout_sop, dout_eop);
            end else begin
                it = exp_q.pop_front();
                if ({dout, dout_sop, dout_eop} !== {it.sym, it.sop, it.eop}) begin
                    n_err++;
                    $display("FAIL dout_symbol: got sym=%02h sop=%b eop=%b, required sym=%02h sop=%b eop=%b (cycle %0d)",
                             dout, dout_sop, dout_eop, it.sym, it.sop, it.eop, cyc);
                end
                if (it.sop) begin
                    sop_cyc  = cyc;
                    par_seen = 0;
                end
                if (it.par) par_seen++;
                if (it.eop) eop_cyc = cyc;
            end
        end
    end

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return 8'(gexp[glog[a] + glog[b]]);
    endfunction

    task automatic init_model();
        int x;
        gexp[0] = 1;
        for (int i = 1; i < 255; i++) begin
            x = gexp[i-1] << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
            gexp[i] = x;
        end
        for (int i = 255; i < 512; i++) gexp[i] = gexp[i-255];
        for (int i = 0; i < 256; i++) glog[i] = 0;
        for (int i = 0; i < 255; i++) glog[gexp[i]] = i;
        for (int j = 0; j <= R; j++) gen[j] = 8'd0;
        gen[0] = 8'd1;
        for (int i = 0; i < R; i++) begin
            for (int j = i + 1; j >= 1; j--) gen[j] = gen[j-1] ^ mul(gen[j], 8'(gexp[i]));
            gen[0] = mul(gen[0], 8'(gexp[i]));
        end
    endtask

    // Long division of m(x)*x^R by g(x); remainder pushed highest degree first.
    task automatic push_parity(input logic [7:0] msg[$]);
        logic [7:0] c [0:511];
        logic [7:0] coef;
        int k = msg.size();
        for (int d = 0; d < 512; d++) c[d] = 8'd0;
        for (int i = 0; i < k; i++) c[k+R-1-i] = msg[i];
        for (int d = k + R - 1; d >= R; d--) begin
            coef = c[d];
            if (coef != 8'd0)
                for (int i = 0; i <= R; i++) c[d-R+i] = c[d-R+i] ^ mul(coef, gen[i]);
        end
        for (int d = R - 1; d >= 0; d--) exp_q.push_back('{c[d], 1'b0, d == 0, 1'b1});
    endtask

    task automatic drive_sym(input logic [7:0] s, input logic sop, input logic eop, output bit ok);
        ok = 1'b0;
        din = s; din_sop = sop; din_eop = eop; din_val = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (din_rdy) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL drive_timeout: din_rdy stayed 0, required 1");
        end
    endtask

    task automatic send_frame(input logic [7:0] msg[$], input bit with_eop, input bit gaps);
        bit ok;
        int last = msg.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            drive_sym(msg[i], i == 0, with_eop && i == last, ok);
            if (ok) exp_q.push_back('{msg[i], i == 0, 1'b0, 1'b0});
        end
        if (with_eop) push_parity(msg);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({dout_val, dout_sop, dout_eop, frm_err, dout} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %03h, required 000", {dout_val, dout_sop, dout_eop, frm_err, dout});
        end
        n_cmp++;
        if (din_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_din_rdy: got %b, required 0", din_rdy);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (din_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_din_rdy: got %b, required 1", din_rdy);
        end
    endtask

    task automatic test_zero_frame();
        logic [7:0] msg[$];
        int e0 = err_cnt, c0 = out_cnt;
        for (int i = 0; i < KMAX; i++) msg.push_back(8'd0);
        send_frame(msg, 1'b1, 1'b0);
        drain();
        n_cmp++;
        if (exp_q.size() != 0 || out_cnt - c0 != 255) begin
            n_err++;
            $display("FAIL zero_frame_count: got %0d symbols (%0d pending), required 255", out_cnt - c0, exp_q.size());
        end
        n_cmp++;
        if (eop_cyc - sop_cyc != 254) begin
            n_err++;
            $display("FAIL zero_frame_span: got %0d cycles sop->eop, required 254", eop_cyc - sop_cyc);
        end
        n_cmp++;
        if (err_cnt != e0) begin
            n_err++;
            $display("FAIL zero_frame_err: got %0d frm_err pulses, required 0", err_cnt - e0);
        end
    endtask

    task automatic test_k1();
        bit ok;
        int acc;
        drive_sym(8'h01, 1'b1, 1'b1, ok);
        acc = cyc;
        exp_q.push_back('{8'h01, 1'b1, 1'b0, 1'b0});
        for (int j = R - 1; j >= 0; j--) exp_q.push_back('{gen[j], 1'b0, j == 0, 1'b1});
        drain();
        n_cmp++;
        if (exp_q.size() != 0 || eop_cyc - acc != 16) begin
            n_err++;
            $display("FAIL k1_latency: got eop %0d cycles after data (%0d pending), required 16", eop_cyc - acc, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] msg[$];
        int e0 = err_cnt;
        bp_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            msg.delete();
            for (int i = 0; i < int'($urandom_range(1, KMAX)); i++) msg.push_back(8'($urandom));
            send_frame(msg, 1'b1, 1'b1);
        end
        drain();
        bp_en = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0 || err_cnt != e0) begin
            n_err++;
            $display("FAIL random_frames: got %0d pending, %0d frm_err, required 0 and 0", exp_q.size(), err_cnt - e0);
        end
    endtask

    task automatic test_abort();
        logic [7:0] m10[$], m20[$];
        int e0 = err_cnt;
        for (int i = 0; i < 10; i++) m10.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) m20.push_back(8'($urandom));
        send_frame(m10, 1'b0, 1'b0);
        send_frame(m20, 1'b1, 1'b0);
        drain();
        n_cmp++;
        if (exp_q.size() != 0 || err_cnt - e0 != 1) begin
            n_err++;
            $display("FAIL abort_frame: got %0d pending, %0d frm_err, required 0 and 1", exp_q.size(), err_cnt - e0);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] m240[$], m239[$];
        bit ok;
        int e0 = err_cnt;
        for (int i = 0; i < 240; i++) m240.push_back(8'($urandom));
        m239 = m240[0:238];
        send_frame(m239, 1'b0, 1'b0);
        push_parity(m239);
        drive_sym(m240[239], 1'b0, 1'b0, ok);
        drain();
        n_cmp++;
        if (exp_q.size() != 0 || err_cnt - e0 != 2) begin
            n_err++;
            $display("FAIL overrun: got %0d pending, %0d frm_err, required 0 and 2", exp_q.size(), err_cnt - e0);
        end
    endtask

    task automatic test_reset_parity();
        logic [7:0] msg[$];
        bit hit = 1'b0;
        for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
        send_frame(msg, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (par_seen >= 5) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL reset_parity_reach: got %0d parity symbols, required 5", par_seen);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dout_val, dout_sop, dout_eop, frm_err, din_rdy, dout} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_mid_parity: got %04h, required 0000", {dout_val, dout_sop, dout_eop, frm_err, din_rdy, dout});
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_zero_frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        init_model();
        test_reset();
        test_zero_frame();
        test_k1();
        test_random();
        test_abort();
        test_overrun();
        test_reset_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
